// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch front end with a small prefetch FIFO.
// Issues word-aligned fetches to a synchronous instruction memory (1-cycle latency).
// Each returned word is captured with its PC, and the oldest entry is presented to decode.
// Optional build macro: IFETCH_MISALIGN_CHECK_EN enables the sticky misaligned-redirect flag.
module ifetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall_d,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid_d,
    output logic [31:0] o_instr_d,
    output logic [31:0] o_pc_d,
    output logic [31:0] o_pcplus4_d,
    output logic        o_fetch_misaligned
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [31:0]      r_fetch_pc;
    logic             r_inflight;
    logic [31:0]      r_inflight_pc;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_mem_instr [DEPTH];
    logic [31:0]      r_mem_pc    [DEPTH];

    logic [CNT_W-1:0] w_credit;
    logic             w_req;
    logic             w_capture;
    logic             w_valid;
    logic             w_dequeue;
    logic             w_misaligned;

`ifdef IFETCH_MISALIGN_CHECK_EN
    logic r_misaligned;

    // Sticky flag: a redirect to a non-word-aligned target halts fetch until reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_misaligned <= 1'b0;
        end else if (i_redirect && (i_redirect_pc[1:0] != 2'b00)) begin
            r_misaligned <= 1'b1;
        end
    end

    assign w_misaligned = r_misaligned;
`else
    // Low target bits are dropped: fetch always uses the aligned address.
    logic w_unused_pc_lsb;
    assign w_unused_pc_lsb = ^i_redirect_pc[1:0];
    assign w_misaligned    = 1'b0;
`endif

    // Entries held plus the one response still in flight must never exceed DEPTH,
    // so a capture always finds a free slot.
    assign w_credit  = r_count + CNT_W'(r_inflight);
    assign w_req     = !i_reset && !i_redirect && !w_misaligned && (w_credit < DEPTH_C);
    assign w_capture = r_inflight && !i_redirect;
    assign w_valid   = (r_count != '0) && !w_misaligned;
    assign w_dequeue = w_valid && !i_stall_d && !i_redirect;

    assign o_imem_req         = w_req;
    assign o_imem_addr        = {r_fetch_pc[31:2], 2'b00};
    assign o_fetch_misaligned = w_misaligned;

    // Fetch PC, in-flight tracking, queue pointers and occupancy.
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; a blocking write here would leak into later reads in this block.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else if (i_redirect) begin
            r_fetch_pc <= {i_redirect_pc[31:2], 2'b00};
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_req) begin
                r_fetch_pc    <= r_fetch_pc + 32'd4;
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_fetch_pc;
            end else begin
                r_inflight <= 1'b0;
            end
            if (w_capture) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_dequeue) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_capture, w_dequeue})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage: write the returning word and its PC at the tail.
    // NOTE: the storage array is deliberately not reset; occupancy and pointers
    // decide what is visible, so stale contents can never reach decode.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_capture) begin
            r_mem_instr[r_wr_ptr] <= i_imem_rdata;
            r_mem_pc[r_wr_ptr]    <= r_inflight_pc;
        end
    end

    // Head-of-queue presentation to decode; idle values when nothing is valid.
    // NOTE: every output gets a default before the condition so no latch is inferred.
    always_comb begin
        o_valid_d   = 1'b0;
        o_instr_d   = NOP_INSTR;
        o_pc_d      = '0;
        o_pcplus4_d = '0;
        if (w_valid) begin
            o_valid_d   = 1'b1;
            o_instr_d   = r_mem_instr[r_rd_ptr];
            o_pc_d      = r_mem_pc[r_rd_ptr];
            o_pcplus4_d = r_mem_pc[r_rd_ptr] + 32'd4;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: randomized scoreboard bench for ifetch_queue (default parameters).
// The stimulus process extends the expected decode PC stream every cycle; a monitor
// on the falling edge pops it on each dequeue and checks fetch addresses and timing.
module tb_ifetch_queue;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] DATA_BASE = 32'h1000_0000;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_rdata = 32'h0;
    logic        i_stall_d = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'h0;
    logic        o_valid_d;
    logic [31:0] o_instr_d;
    logic [31:0] o_pc_d;
    logic [31:0] o_pcplus4_d;
    logic        o_fetch_misaligned;

    ifetch_queue dut (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .o_imem_req         (o_imem_req),
        .o_imem_addr        (o_imem_addr),
        .i_imem_rdata       (i_imem_rdata),
        .i_stall_d          (i_stall_d),
        .i_redirect         (i_redirect),
        .i_redirect_pc      (i_redirect_pc),
        .o_valid_d          (o_valid_d),
        .o_instr_d          (o_instr_d),
        .o_pc_d             (o_pc_d),
        .o_pcplus4_d        (o_pcplus4_d),
        .o_fetch_misaligned (o_fetch_misaligned)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected decode stream for the current fetch segment.
    logic [31:0] exp_q [$];
    logic [31:0] exp_tail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory: 1-cycle latency, word = DATA_BASE + address.
    logic        mem_pend = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    always @(negedge i_clk) begin
        mem_pend = o_imem_req;
        mem_addr = o_imem_addr;
    end
    always @(posedge i_clk) begin
        #1;
        i_imem_rdata = mem_pend ? (DATA_BASE + mem_addr) : $urandom();
    end

    // Apply one cycle of inputs and extend the expected decode stream.
    task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] tgt);
        @(posedge i_clk);
        #1;
        i_reset       = r;
        i_stall_d     = s;
        i_redirect    = rd;
        i_redirect_pc = tgt;
        if (r) begin
            exp_q.delete();
            exp_tail = RESET_PC;
        end else if (rd) begin
            exp_q.delete();
            exp_tail = {tgt[31:2], 2'b00};
        end else begin
            exp_tail = exp_tail + 32'd4;
        end
        exp_q.push_back(exp_tail);
    endtask

    // Monitor: timing, fetch-address sequence and scoreboard comparison.
    int          since     = 0;
    logic [31:0] next_addr = RESET_PC;
    logic        mis_model = 1'b0;
    logic        exp_valid;
    logic [31:0] exp_pc;

    always @(negedge i_clk) begin
        if (i_reset) begin
            check("req_in_reset", o_imem_req, 0);
            since     = 0;
            next_addr = RESET_PC;
            mis_model = 1'b0;
        end else begin
            exp_valid = (since >= 2) && !mis_model;
            check("valid_d", o_valid_d, exp_valid);
            check("fetch_misaligned", o_fetch_misaligned, mis_model);
            if (!o_valid_d) begin
                check("idle_instr", o_instr_d, NOP_INSTR);
                check("idle_pc", o_pc_d, 0);
                check("idle_pcplus4", o_pcplus4_d, 0);
            end
            if (i_redirect || mis_model) begin
                check("req_blocked", o_imem_req, 0);
            end else if (o_imem_req) begin
                check("imem_addr", o_imem_addr, next_addr);
                next_addr = next_addr + 32'd4;
            end
            if (o_valid_d && !i_stall_d && !i_redirect) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 1, 0);
                end else begin
                    exp_pc = exp_q.pop_front();
                    check("pc_d", o_pc_d, exp_pc);
                    check("instr_d", o_instr_d, DATA_BASE + exp_pc);
                    check("pcplus4_d", o_pcplus4_d, exp_pc + 32'd4);
                end
            end
            if (i_redirect) begin
                since     = 0;
                next_addr = {i_redirect_pc[31:2], 2'b00};
`ifdef IFETCH_MISALIGN_CHECK_EN
                if (i_redirect_pc[1:0] != 2'b00) mis_model = 1'b1;
`endif
            end else if (since < 1000) begin
                since++;
            end
        end
    end

    initial begin
        logic        r;
        logic        s;
        logic        rd;
        logic [31:0] tgt;
        exp_tail = RESET_PC;

        // Reset, then free-running fetch for two cycles.
        repeat (3) drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        // Stall for 10 cycles from the first valid: queue fills, fetch stops, head holds.
        repeat (10) drive(0, 1, 0, 0);
        @(negedge i_clk);
        check("stall_full_req", o_imem_req, 0);
        check("stall_hold_pc", o_pc_d, 0);
        check("stall_hold_valid", o_valid_d, 1);
        repeat (10) drive(0, 0, 0, 0);

        // Redirect with a few entries queued.
        repeat (2) drive(0, 1, 0, 0);
        drive(0, 0, 1, 32'h0000_0200);
        repeat (8) drive(0, 0, 0, 0);

        // Redirect together with stall on a full queue.
        repeat (8) drive(0, 1, 0, 0);
        drive(0, 1, 1, 32'h0000_0300);
        repeat (8) drive(0, 0, 0, 0);

        // Fetch across the top of the address space.
        drive(0, 0, 1, 32'hFFFF_FFF8);
        repeat (8) drive(0, 0, 0, 0);

        // Randomized traffic: stalls, aligned redirects, occasional reset.
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 199) == 0);
            rd  = !r && ($urandom_range(0, 29) == 0);
            s   = ($urandom_range(0, 9) < 3);
            tgt = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFE0 | (tgt & 32'h0000_001C);
            drive(r, s, rd, tgt);
        end

        // Misaligned redirect target, then recovery through reset.
        drive(0, 0, 0, 0);
        drive(0, 0, 1, 32'h0000_0102);
        repeat (8) drive(0, 0, 0, 0);
        @(negedge i_clk);
`ifdef IFETCH_MISALIGN_CHECK_EN
        check("misalign_sticky", o_fetch_misaligned, 1);
        check("misalign_no_req", o_imem_req, 0);
        check("misalign_no_valid", o_valid_d, 0);
`else
        check("misalign_ignored", o_fetch_misaligned, 0);
        check("misalign_valid", o_valid_d, 1);
`endif
        repeat (2) drive(1, 0, 0, 0);
        repeat (8) drive(0, 0, 0, 0);

        @(negedge i_clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end that generates fetch addresses into a synchronous instruction memory.
- Captures each returned word together with its PC in a small prefetch FIFO.
- Presents the oldest entry (instr, pc, pc+4) to the core's decode stage.
- Honours the decode stall from the hazard unit, and honours branch/jump redirects that flush the queue and restart fetch at a new target.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value driven on instr_d whenever valid_d=0 (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-high.
- imem_req  output  1  fetch request this cycle.
- imem_addr  output  32  fetch address; always word-aligned.
- imem_rdata  input  32  instruction word, valid the cycle after imem_req=1 (fixed 1-cycle latency).
- stall_d  input  1  decode stall; the head entry is held while high.
- redirect  input  1  taken branch/jump resolved downstream.
- redirect_pc  input  32  new fetch target, sampled when redirect=1.
- valid_d  output  1  head entry valid.
- instr_d  output  32  head instruction; NOP_INSTR when valid_d=0.
- pc_d  output  32  PC of head instruction; 0 when valid_d=0.
- pcplus4_d  output  32  pc_d+4 (mod 2^32); 0 when valid_d=0.
- fetch_misaligned  output  1  see Optional Feature; constant 0 when the feature is compiled out.

Behaviour:
- State registers:
  - fetch_pc (next address to request);
  - inflight flag and inflight_pc (request issued last cycle);
  - queue storage with rd_ptr/wr_ptr of log2(DEPTH) bits, wrapping naturally;
  - count of 0..DEPTH.
- Reset: fetch_pc=RESET_PC, inflight=0, count=0, pointers=0, valid_d=0, instr_d=NOP_INSTR, pc_d=0, pcplus4_d=0, imem_req=0 during the reset cycle, fetch_misaligned=0.
- Request rule (combinational): imem_req = !reset && !redirect && (count + inflight < DEPTH); imem_addr = {fetch_pc[31:2],2'b00}.
  - On an issued request: fetch_pc += 4, inflight<=1, inflight_pc<=fetch_pc. Otherwise inflight<=0.
- Capture: when inflight=1 and no redirect this cycle, {imem_rdata, inflight_pc} is written at wr_ptr at the clock edge.
  - The credit rule guarantees the queue is never full at capture; overflow cannot occur.
- Dequeue: when valid_d && !stall_d, rd_ptr advances at the edge.
  - Capture and dequeue in the same cycle leave count unchanged.
- Output: valid_d = (count != 0). instr_d, pc_d and pcplus4_d are driven from the head entry.
- Latency:
  - A request issued in cycle t is captured at the end of t+1 and visible on valid_d in t+2.
  - The steady-state throughput is 1 instr/cycle when stall_d=0.
- Redirect in cycle t:
  - At that edge: count<=0, rd_ptr=wr_ptr<=0, inflight<=0, fetch_pc<=redirect_pc.
  - The response returning in cycle t+1 for a cycle-t request is impossible, because no request is issued in cycle t.
  - A response already arriving in cycle t, from a cycle t-1 request, is discarded.
  - Cycle t+1 requests redirect_pc; that instruction becomes valid in t+3.
- Priority: reset > redirect > capture/dequeue.
  - Redirect together with stall_d: redirect wins.
  - Redirect together with a dequeue: the dequeue is ignored, since that entry is flushed.
- Stall with a full queue: requests stop; outputs hold stable for any number of cycles; no entry is lost or duplicated.
- Reset asserted mid-operation: all state returns to reset values at that edge; any inflight response is dropped.
- PC arithmetic is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0.

Optional Feature:
- Macro: IFETCH_MISALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 sets fetch_misaligned=1 at that edge; it stays sticky until reset.
  - While fetch_misaligned=1, imem_req is forced to 0 and valid_d stays 0.
- Undefined:
  - redirect_pc[1:0] are silently ignored, because fetch uses the aligned address.
  - fetch_misaligned is tied to 0.

Test Plan:
- Reset release, stall_d=0, imem returns 32'h1000_0000+addr -> imem_addr 0,4,8,... on consecutive cycles; first valid_d two cycles after the first request with pc_d=0, instr_d=32'h1000_0000, pcplus4_d=4; then one instruction per cycle.
- Hold stall_d=1 for 10 cycles from the first valid_d -> exactly DEPTH=4 entries are buffered and imem_req drops; pc_d is held at 0. After releasing stall_d, pc_d runs 0,4,8,12,16 with no gap or duplicate.
- redirect=1, redirect_pc=32'h0000_0200 while 3 entries are queued -> valid_d=0 next cycle; imem_addr=0x200 on the next cycle; pc_d=0x200 valid three cycles after the redirect; old entries never appear.
- redirect and stall_d asserted together with the queue full -> flush takes effect and refetch proceeds from redirect_pc.
- Fetch running across 32'hFFFF_FFF8 -> pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, with pcplus4_d for FFFF_FFFC equal to 0.
- With IFETCH_MISALIGN_CHECK_EN defined, redirect_pc=32'h0000_0102 -> fetch_misaligned=1 sticky, imem_req=0, valid_d=0 until reset. With the macro undefined, the same stimulus fetches 0x100 and fetch_misaligned=0.
